ps2_packet_assembler: RTL and testbench

Assembles the 3-byte PS/2 mouse movement packet from the byte stream of the PS/2 receiver (`ps2_keyboard` instance fed by `PS2_clk`/`PS2_data`). Converts it into the magnitude/direction form consumed by `objectMouseMove` (`vx`, `vy`, `dx`, `dy`) plus button state. Replaces the ad-hoc packet state machine and sign conversion in `top`. Adds header synchronisation, mid-packet timeout and overflow saturation.

---
 rtl/ps2_packet_assembler.sv | 192 +++++++++++++++++++
 tb/tb_ps2_packet_assembler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_packet_assembler.sv
// PS/2 mouse packet assembler: header sync, timeout, overflow saturation.
// Optional header bit3 check enabled by defining PS2_PKT_SYNC_CHECK_EN.
module ps2_packet_assembler #(
  parameter int TIMEOUT_CYCLES = 10_000_000,
  parameter int VSHIFT         = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       byte_ready,
  input  logic [7:0] byte_data,
  output logic       pkt_valid,
  output logic [9:0] vx,
  output logic [9:0] vy,
  output logic       dx,
  output logic       dy,
  output logic       btn_left,
  output logic       btn_right,
  output logic       btn_middle,
  output logic       x_ovf,
  output logic       y_ovf,
  output logic       sync_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2
  } state_t;

  state_t        state;
  state_t        state_n;
  logic          s1;
  logic          s2;
  logic          s3;
  logic          accept;
  logic          hdr_ok;
  logic          term;
  logic [CW-1:0] cnt;
  logic [7:0]    hdr;
  logic [7:0]    xb;
  logic          latch_hdr;
  logic          latch_x;
  logic          decode;
  logic          bad_hdr;
  logic          idle_clr;
  logic [8:0]    mag_x;
  logic [8:0]    mag_y;

  assign accept = s2 & ~s3;
  assign term   = (cnt == TERM);

`ifdef PS2_PKT_SYNC_CHECK_EN
  assign hdr_ok = byte_data[3];
`else
  assign hdr_ok = 1'b1;
`endif

  // Two-flop synchroniser plus edge-detect flop for byte_ready.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= byte_ready;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Idle counter: cleared by an accept, saturates at the terminal value.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (!term) begin
      cnt <= cnt + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= B0;
    end else begin
      state <= state_n;
    end
  end

  // Next state: an accept always beats a simultaneous timeout.
  always_comb begin
    state_n = state;
    unique case (state)
      B0: if (accept && hdr_ok) state_n = B1;
      B1: begin
        if (accept) state_n = B2;
        else if (term) state_n = B0;
      end
      B2: begin
        if (accept) state_n = B0;
        else if (term) state_n = B0;
      end
      default: state_n = B0;
    endcase
  end

  // Per-state control strobes.
  always_comb begin
    latch_hdr = 1'b0;
    latch_x   = 1'b0;
    decode    = 1'b0;
    bad_hdr   = 1'b0;
    idle_clr  = 1'b0;
    unique case (state)
      B0: begin
        latch_hdr = accept & hdr_ok;
        bad_hdr   = accept & ~hdr_ok;
        idle_clr  = term & ~accept;
      end
      B1: latch_x = accept;
      B2: decode  = accept;
      default: ;
    endcase
  end

  // Hold the header and X byte until the Y byte arrives.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hdr <= 8'h00;
      xb  <= 8'h00;
    end else begin
      if (latch_hdr) hdr <= byte_data;
      if (latch_x) xb <= byte_data;
    end
  end

  function automatic logic [8:0] mag9(
    input logic       sgn,
    input logic [7:0] b,
    input logic       ovf
  );
    logic [8:0] v;
    v = {sgn, b};
    if (ovf) return 9'd255;
    return sgn ? (~v + 9'd1) : v;
  endfunction

  // Sign/magnitude conversion of both axes.
  always_comb begin
    mag_x = mag9(hdr[4], xb, hdr[6]);
    mag_y = mag9(hdr[5], byte_data, hdr[7]);
  end

  // Registered decode; idle timeout in B0 zeroes only the velocity.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pkt_valid  <= 1'b0;
      sync_err   <= 1'b0;
      vx         <= 10'd0;
      vy         <= 10'd0;
      dx         <= 1'b0;
      dy         <= 1'b0;
      btn_left   <= 1'b0;
      btn_right  <= 1'b0;
      btn_middle <= 1'b0;
      x_ovf      <= 1'b0;
      y_ovf      <= 1'b0;
    end else begin
      pkt_valid <= decode;
      sync_err  <= bad_hdr;
      if (decode) begin
        vx         <= {1'b0, mag_x >> VSHIFT};
        vy         <= {1'b0, mag_y >> VSHIFT};
        dx         <= ~hdr[4];
        dy         <= ~hdr[5];
        btn_left   <= hdr[0];
        btn_right  <= hdr[1];
        btn_middle <= hdr[2];
        x_ovf      <= hdr[6];
        y_ovf      <= hdr[7];
      end else if (idle_clr) begin
        vx <= 10'd0;
        vy <= 10'd0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_packet_assembler.sv
// Randomised scoreboard bench for ps2_packet_assembler.
// Reference model decodes packets arithmetically from the byte stream.
module tb_ps2_packet_assembler;

  localparam int TO = 100;
  localparam int VS = 1;

  typedef struct packed {
    logic [9:0] vx;
    logic [9:0] vy;
    logic       dx;
    logic       dy;
    logic [2:0] btn;
    logic       xo;
    logic       yo;
  } pkt_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       byte_ready = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       pkt_valid;
  logic [9:0] vx;
  logic [9:0] vy;
  logic       dx;
  logic       dy;
  logic       btn_left;
  logic       btn_right;
  logic       btn_middle;
  logic       x_ovf;
  logic       y_ovf;
  logic       sync_err;

  ps2_packet_assembler #(.TIMEOUT_CYCLES(TO), .VSHIFT(VS)) dut (
    .clk(clk), .rstn(rstn),
    .byte_ready(byte_ready), .byte_data(byte_data),
    .pkt_valid(pkt_valid), .vx(vx), .vy(vy),
    .dx(dx), .dy(dy),
    .btn_left(btn_left), .btn_right(btn_right),
    .btn_middle(btn_middle),
    .x_ovf(x_ovf), .y_ovf(y_ovf), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   passed = 0;
  pkt_t expq[$];
  pkt_t last = '0;
  int   nb = 0;
  logic [7:0] m_hdr;
  logic [7:0] m_x;
  int   exp_sync = 0;
  int   seen_sync = 0;

  function automatic pkt_t cur();
    return {vx, vy, dx, dy,
            btn_middle, btn_right, btn_left,
            x_ovf, y_ovf};
  endfunction

  function automatic int axis_mag(
    input logic sgn, input logic [7:0] b, input logic ovf
  );
    int v;
    v = sgn ? int'(b) - 256 : int'(b);
    if (ovf) return 255;
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    pkt_t p;
    if (nb == 0) begin
`ifdef PS2_PKT_SYNC_CHECK_EN
      if (!b[3]) begin
        exp_sync++;
        return;
      end
`endif
      m_hdr = b;
      nb = 1;
    end else if (nb == 1) begin
      m_x = b;
      nb = 2;
    end else begin
      p.vx  = 10'(axis_mag(m_hdr[4], m_x, m_hdr[6]) >> VS);
      p.vy  = 10'(axis_mag(m_hdr[5], b, m_hdr[7]) >> VS);
      p.dx  = !m_hdr[4];
      p.dy  = !m_hdr[5];
      p.btn = m_hdr[2:0];
      p.xo  = m_hdr[6];
      p.yo  = m_hdr[7];
      expq.push_back(p);
      last = p;
      nb = 0;
    end
  endtask

  task automatic check(
    input string nm, input pkt_t act, input pkt_t req
  );
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, req);
  endtask

  task automatic send_byte(
    input logic [7:0] b, input int hi, input int lo
  );
    model_byte(b);
    @(negedge clk);
    byte_data = b;
    byte_ready = 1'b1;
    repeat (hi) @(negedge clk);
    byte_ready = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send3(input logic [7:0] a, b, c);
    send_byte(a, 4, 4);
    send_byte(b, 4, 4);
    send_byte(c, 4, 4);
  endtask

  task automatic idle_check(input string nm);
    pkt_t r;
    repeat (TO + 20) @(negedge clk);
    nb = 0;
    last.vx = 10'd0;
    last.vy = 10'd0;
    r = last;
    check(nm, cur(), r);
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (pkt_valid && sync_err) begin
        checks++;
        $display("FAIL overlap: pkt_valid=1 sync_err=1 want not both");
      end
      if (sync_err) seen_sync++;
      if (pkt_valid) begin
        if (expq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_pkt: got %h want none", cur());
        end else begin
          check("pkt", cur(), expq.pop_front());
        end
      end
    end
  end

  initial begin
    logic [7:0] h;
    int n;
    repeat (3) @(negedge clk);
    check("reset_state", cur(), '0);
    checks++;
    if (!pkt_valid && !sync_err) passed++;
    else $display("FAIL reset_pulses: got %b%b want 00",
                  pkt_valid, sync_err);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    send3(8'h09, 8'h05, 8'hFC);
    idle_check("idle_after_basic");
    send_byte(8'h00, 4, 4);
    send3(8'h08, 8'h00, 8'h00);
    idle_check("idle_after_sync");
    send3(8'h48, 8'h10, 8'h00);
    send3(8'h18, 8'h00, 8'h00);
    send_byte(8'h18, 25, 5);
    send_byte(8'h7F, 3, 2);
    send_byte(8'h80, 3, 2);
    send_byte(8'h08, 4, 4);
    send_byte(8'h10, 4, 4);
    idle_check("timeout_partial");
    send3(8'h08, 8'h02, 8'h02);
    idle_check("timeout_vel");

    send_byte(8'h09, 4, 4);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    nb = 0;
    last = '0;
    check("mid_reset", cur(), '0);
    rstn = 1'b1;
    @(negedge clk);
    send3(8'h0A, 8'h00, 8'h00);

    n = 0;
    while (n < 60) begin
      h = 8'($urandom);
      if ($urandom_range(0, 3) != 0) h[3] = 1'b1;
      send_byte(h, $urandom_range(3, 10), $urandom_range(2, 8));
      n++;
      if ($urandom_range(0, 15) == 0) idle_check("rand_idle");
    end
    idle_check("final_idle");

    checks++;
    if (expq.size() == 0) passed++;
    else $display("FAIL missing_pkts: got %0d left want 0", expq.size());
    checks++;
    if (seen_sync == exp_sync) passed++;
    else $display("FAIL sync_count: got %0d want %0d",
                  seen_sync, exp_sync);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
